// File: rtl/usbdev_pkg.sv
// Shared USB device link-layer types: link-state and remote-wakeup encodings,
// default wakeup timing and the transceiver drive payload.
package usbdev_pkg;

  localparam int unsigned IdleUs     = 5000;
  localparam int unsigned DriveUs    = 2000;
  localparam int unsigned HostWaitUs = 50000;

  localparam int unsigned SuspTimerW = 13;
  localparam int unsigned WakeTimerW = 16;

  typedef enum logic [2:0] {
    LinkDisconnected = 3'd0,
    LinkPowered      = 3'd1,
    LinkPoweredSusp  = 3'd2,
    LinkActive       = 3'd3,
    LinkSuspended    = 3'd4,
    LinkActiveNoSof  = 3'd5,
    LinkResuming     = 3'd6
  } link_state_e;

  typedef enum logic [1:0] {
    WakeIdle     = 2'd0,
    WakeArmed    = 2'd1,
    WakeDriveK   = 2'd2,
    WakeWaitHost = 2'd3
  } wake_gen_state_e;

  typedef struct packed {
    logic oe;
    logic dp;
    logic dn;
  } usb_drive_t;

  // K state (D+ low, D- high) only while driving; bus released otherwise.
  function automatic usb_drive_t drive_for(wake_gen_state_e s);
    usb_drive_t d;
    d = '0;
    if (s == WakeDriveK) begin
      d.oe = 1'b1;
      d.dp = 1'b0;
      d.dn = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/usbdev_wake_gen_if.sv
// Signal bundle between link-state/software side and the remote-wakeup generator.
interface usbdev_wake_gen_if;

  logic us_tick_i;
  logic link_suspend_i;
  logic link_active_i;
  logic link_disconnect_i;
  logic wake_req_i;
  logic usb_oe_o;
  logic usb_dp_o;
  logic usb_dn_o;
  logic wake_busy_o;
  logic wake_done_o;
  logic wake_fail_o;

  modport master (
    output us_tick_i, link_suspend_i, link_active_i, link_disconnect_i, wake_req_i,
    input  usb_oe_o, usb_dp_o, usb_dn_o, wake_busy_o, wake_done_o, wake_fail_o
  );

  modport slave (
    input  us_tick_i, link_suspend_i, link_active_i, link_disconnect_i, wake_req_i,
    output usb_oe_o, usb_dp_o, usb_dn_o, wake_busy_o, wake_done_o, wake_fail_o
  );

endinterface

// File: rtl/usbdev_wake_gen.sv
// Remote-wakeup transmitter: after a settled suspend, drives K for a fixed
// interval, releases the bus and waits for the host to reactivate the link.
module usbdev_wake_gen #(
  parameter int unsigned IdleUs     = usbdev_pkg::IdleUs,
  parameter int unsigned DriveUs    = usbdev_pkg::DriveUs,
  parameter int unsigned HostWaitUs = usbdev_pkg::HostWaitUs
) (
  input  logic               clk_48mhz_i,
  input  logic               rst_ni,
  usbdev_wake_gen_if.slave   bus
);

  import usbdev_pkg::*;

  localparam logic [SuspTimerW-1:0] IdleMax   = SuspTimerW'(IdleUs);
  localparam logic [WakeTimerW-1:0] DriveLast = WakeTimerW'(DriveUs - 1);
  localparam logic [WakeTimerW-1:0] HostLast  = WakeTimerW'(HostWaitUs - 1);

  wake_gen_state_e        state_q, state_d;
  logic [SuspTimerW-1:0]  susp_q;
  logic [WakeTimerW-1:0]  wake_q;
  logic                   settled;
  logic                   done_d, fail_d;
  usb_drive_t             drive_q;
  logic                   busy_q, done_q, fail_q;

  assign settled = (susp_q == IdleMax);

  // Continuous-suspend timer, saturating at the settling threshold.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      susp_q <= '0;
    end else if (!bus.link_suspend_i) begin
      susp_q <= '0;
    end else if (bus.us_tick_i && !settled) begin
      susp_q <= susp_q + SuspTimerW'(1);
    end
  end

  // Next-state and completion pulses; link_suspend_i is ignored in DriveK
  // because our own K drive disturbs it.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      WakeIdle: begin
        if (bus.wake_req_i) begin
          if (bus.link_suspend_i && !bus.link_disconnect_i) begin
            state_d = WakeArmed;
          end else begin
            fail_d = 1'b1;
          end
        end
      end
      WakeArmed: begin
        if (bus.link_disconnect_i) begin
          state_d = WakeIdle;
          fail_d  = 1'b1;
        end else if (!bus.link_suspend_i) begin
          state_d = WakeIdle;
          done_d  = 1'b1;
        end else if (settled) begin
          state_d = WakeDriveK;
        end
      end
      WakeDriveK: begin
        if (bus.link_disconnect_i) begin
          state_d = WakeIdle;
          fail_d  = 1'b1;
        end else if (bus.us_tick_i && (wake_q == DriveLast)) begin
          state_d = WakeWaitHost;
        end
      end
      WakeWaitHost: begin
        if (bus.link_disconnect_i) begin
          state_d = WakeIdle;
          fail_d  = 1'b1;
        end else if (bus.link_active_i) begin
          state_d = WakeIdle;
          done_d  = 1'b1;
        end else if (bus.us_tick_i && (wake_q == HostLast)) begin
          state_d = WakeIdle;
          fail_d  = 1'b1;
        end
      end
      default: begin
        state_d = WakeIdle;
      end
    endcase
  end

  // Wake timer restarts on every state entry; only meaningful in DriveK/WaitHost.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wake_q <= '0;
    end else if ((state_d != state_q) || (state_q == WakeIdle) || (state_q == WakeArmed)) begin
      wake_q <= '0;
    end else if (bus.us_tick_i) begin
      wake_q <= wake_q + WakeTimerW'(1);
    end
  end

  // State register with all outputs loaded from next-state.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WakeIdle;
      drive_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drive_q <= drive_for(state_d);
      busy_q  <= (state_d != WakeIdle);
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.usb_oe_o    = drive_q.oe;
  assign bus.usb_dp_o    = drive_q.dp;
  assign bus.usb_dn_o    = drive_q.dn;
  assign bus.wake_busy_o = busy_q;
  assign bus.wake_done_o = done_q;
  assign bus.wake_fail_o = fail_q;

  a_done_fail_excl: assert property (@(posedge clk_48mhz_i) disable iff (!rst_ni)
    !(bus.wake_done_o && bus.wake_fail_o));

  a_oe_differential: assert property (@(posedge clk_48mhz_i) disable iff (!rst_ni)
    bus.usb_oe_o |-> (bus.usb_dp_o != bus.usb_dn_o));

endmodule

// File: tb/tb_usbdev_wake_gen.sv
// Directed bench for usbdev_wake_gen with shortened timing parameters.
module tb_usbdev_wake_gen;

  localparam int unsigned IDLE     = 50;
  localparam int unsigned DRIVE    = 20;
  localparam int unsigned HOSTWAIT = 100;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  usbdev_wake_gen_if bus();

  usbdev_wake_gen #(
    .IdleUs     (IDLE),
    .DriveUs    (DRIVE),
    .HostWaitUs (HOSTWAIT)
  ) dut (
    .clk_48mhz_i (clk),
    .rst_ni      (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One us tick followed by three quiet cycles; ends on a negedge.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.us_tick_i = 1'b1;
      @(negedge clk);
      bus.us_tick_i = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic pulse_req();
    bus.wake_req_i = 1'b1;
    @(negedge clk);
    bus.wake_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", bus.usb_oe_o); end
    checks++; if (bus.usb_dp_o !== 1'b0) begin errors++; $display("FAIL reset_dp: got %b expected 0", bus.usb_dp_o); end
    checks++; if (bus.usb_dn_o !== 1'b0) begin errors++; $display("FAIL reset_dn: got %b expected 0", bus.usb_dn_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.wake_busy_o); end
    checks++; if (bus.wake_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.wake_done_o); end
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", bus.wake_fail_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int bad;
    bus.link_suspend_i = 1'b1;
    do_ticks(IDLE + 10);
    pulse_req();
    checks++; if (bus.wake_busy_o !== 1'b1) begin errors++; $display("FAIL nom_armed_busy: got %b expected 1", bus.wake_busy_o); end
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL nom_armed_oe: got %b expected 0", bus.usb_oe_o); end
    @(negedge clk);
    checks++; if ({bus.usb_oe_o, bus.usb_dp_o, bus.usb_dn_o} !== 3'b101) begin errors++; $display("FAIL nom_drive_k: got %b expected 101", {bus.usb_oe_o, bus.usb_dp_o, bus.usb_dn_o}); end
    bad = 0;
    for (int i = 0; i < int'(DRIVE); i++) begin
      if (i == 5) bus.link_suspend_i = 1'b0;
      bus.us_tick_i = 1'b1;
      @(negedge clk);
      bus.us_tick_i = 1'b0;
      if (i < int'(DRIVE) - 1) begin
        repeat (3) begin
          if ({bus.usb_oe_o, bus.usb_dp_o, bus.usb_dn_o} !== 3'b101) bad++;
          @(negedge clk);
        end
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL nom_drive_window: got %0d bad cycles expected 0", bad); end
    checks++; if ({bus.usb_oe_o, bus.usb_dp_o, bus.usb_dn_o} !== 3'b000) begin errors++; $display("FAIL nom_release: got %b expected 000", {bus.usb_oe_o, bus.usb_dp_o, bus.usb_dn_o}); end
    checks++; if (bus.wake_busy_o !== 1'b1) begin errors++; $display("FAIL nom_waithost_busy: got %b expected 1", bus.wake_busy_o); end
    do_ticks(80);
    bus.link_active_i = 1'b1;
    @(negedge clk);
    bus.link_active_i = 1'b0;
    checks++; if (bus.wake_done_o !== 1'b1) begin errors++; $display("FAIL nom_done: got %b expected 1", bus.wake_done_o); end
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL nom_no_fail: got %b expected 0", bus.wake_fail_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL nom_idle_busy: got %b expected 0", bus.wake_busy_o); end
    @(negedge clk);
    checks++; if (bus.wake_done_o !== 1'b0) begin errors++; $display("FAIL nom_done_width: got %b expected 0", bus.wake_done_o); end
  endtask

  task automatic test_armed_wait();
    int bad;
    bus.link_suspend_i = 1'b1;
    do_ticks(10);
    pulse_req();
    bad = 0;
    for (int i = 0; i < int'(IDLE) - 11; i++) begin
      bus.us_tick_i = 1'b1;
      @(negedge clk);
      bus.us_tick_i = 1'b0;
      repeat (3) begin
        if (bus.usb_oe_o !== 1'b0 || bus.wake_busy_o !== 1'b1) bad++;
        @(negedge clk);
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL armed_hold: got %0d bad cycles expected 0", bad); end
    bus.us_tick_i = 1'b1;
    @(negedge clk);
    bus.us_tick_i = 1'b0;
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL armed_settle_edge: got %b expected 0", bus.usb_oe_o); end
    @(negedge clk);
    checks++; if (bus.usb_oe_o !== 1'b1) begin errors++; $display("FAIL armed_to_drive: got %b expected 1", bus.usb_oe_o); end
    do_ticks(10);
    bus.link_disconnect_i = 1'b1;
    @(negedge clk);
    bus.link_disconnect_i = 1'b0;
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL disc_release: got %b expected 0", bus.usb_oe_o); end
    checks++; if (bus.wake_fail_o !== 1'b1) begin errors++; $display("FAIL disc_fail: got %b expected 1", bus.wake_fail_o); end
    checks++; if (bus.wake_done_o !== 1'b0) begin errors++; $display("FAIL disc_no_done: got %b expected 0", bus.wake_done_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL disc_busy: got %b expected 0", bus.wake_busy_o); end
    @(negedge clk);
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL disc_fail_width: got %b expected 0", bus.wake_fail_o); end
    bus.link_suspend_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reject();
    pulse_req();
    checks++; if (bus.wake_fail_o !== 1'b1) begin errors++; $display("FAIL rej_fail: got %b expected 1", bus.wake_fail_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL rej_busy: got %b expected 0", bus.wake_busy_o); end
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL rej_oe: got %b expected 0", bus.usb_oe_o); end
    @(negedge clk);
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL rej_fail_width: got %b expected 0", bus.wake_fail_o); end
    bus.link_suspend_i    = 1'b1;
    bus.link_disconnect_i = 1'b1;
    pulse_req();
    checks++; if (bus.wake_fail_o !== 1'b1) begin errors++; $display("FAIL rej_disc_fail: got %b expected 1", bus.wake_fail_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL rej_disc_busy: got %b expected 0", bus.wake_busy_o); end
    bus.link_disconnect_i = 1'b0;
    bus.link_suspend_i    = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_host_resume();
    bus.link_suspend_i = 1'b1;
    do_ticks(5);
    pulse_req();
    checks++; if (bus.wake_busy_o !== 1'b1) begin errors++; $display("FAIL hr_busy: got %b expected 1", bus.wake_busy_o); end
    bus.link_suspend_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.wake_done_o !== 1'b1) begin errors++; $display("FAIL hr_done: got %b expected 1", bus.wake_done_o); end
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL hr_no_fail: got %b expected 0", bus.wake_fail_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL hr_idle: got %b expected 0", bus.wake_busy_o); end
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL hr_oe: got %b expected 0", bus.usb_oe_o); end
    @(negedge clk);
    checks++; if (bus.wake_done_o !== 1'b0) begin errors++; $display("FAIL hr_done_width: got %b expected 0", bus.wake_done_o); end
  endtask

  task automatic test_timeout();
    bus.link_suspend_i = 1'b1;
    do_ticks(IDLE + 5);
    pulse_req();
    @(negedge clk);
    checks++; if (bus.usb_oe_o !== 1'b1) begin errors++; $display("FAIL to_drive: got %b expected 1", bus.usb_oe_o); end
    do_ticks(DRIVE);
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL to_release: got %b expected 0", bus.usb_oe_o); end
    pulse_req();
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL to_req_ignored_fail: got %b expected 0", bus.wake_fail_o); end
    checks++; if (bus.wake_busy_o !== 1'b1) begin errors++; $display("FAIL to_req_ignored_busy: got %b expected 1", bus.wake_busy_o); end
    do_ticks(HOSTWAIT - 1);
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", bus.wake_fail_o); end
    checks++; if (bus.wake_busy_o !== 1'b1) begin errors++; $display("FAIL to_early_busy: got %b expected 1", bus.wake_busy_o); end
    bus.us_tick_i = 1'b1;
    @(negedge clk);
    bus.us_tick_i = 1'b0;
    checks++; if (bus.wake_fail_o !== 1'b1) begin errors++; $display("FAIL to_fail: got %b expected 1", bus.wake_fail_o); end
    checks++; if (bus.wake_done_o !== 1'b0) begin errors++; $display("FAIL to_no_done: got %b expected 0", bus.wake_done_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL to_idle: got %b expected 0", bus.wake_busy_o); end
    @(negedge clk);
    checks++; if (bus.wake_fail_o !== 1'b0) begin errors++; $display("FAIL to_fail_width: got %b expected 0", bus.wake_fail_o); end
  endtask

  task automatic test_async_reset();
    pulse_req();
    @(negedge clk);
    checks++; if (bus.usb_oe_o !== 1'b1) begin errors++; $display("FAIL ar_drive: got %b expected 1", bus.usb_oe_o); end
    do_ticks(3);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL ar_oe: got %b expected 0", bus.usb_oe_o); end
    checks++; if (bus.usb_dn_o !== 1'b0) begin errors++; $display("FAIL ar_dn: got %b expected 0", bus.usb_dn_o); end
    checks++; if (bus.wake_busy_o !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b expected 0", bus.wake_busy_o); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({bus.wake_done_o, bus.wake_fail_o} !== 2'b00) begin errors++; $display("FAIL ar_no_pulse: got %b expected 00", {bus.wake_done_o, bus.wake_fail_o}); end
    checks++; if (bus.usb_oe_o !== 1'b0) begin errors++; $display("FAIL ar_oe_after: got %b expected 0", bus.usb_oe_o); end
  endtask

  initial begin
    errors                = 0;
    checks                = 0;
    rst_n                 = 1'b0;
    bus.us_tick_i         = 1'b0;
    bus.link_suspend_i    = 1'b0;
    bus.link_active_i     = 1'b0;
    bus.link_disconnect_i = 1'b0;
    bus.wake_req_i        = 1'b0;
    test_reset();
    test_nominal();
    test_armed_wait();
    test_reject();
    test_host_resume();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usbdev_wake_gen.md
# usbdev_wake_gen

Device-side remote-wakeup transmitter for the USB device link layer. It is the driving counterpart of the link-state detector. Once the bus has been suspended for the required settling time, a software request makes it drive K-state resume signaling onto D+/D- for a fixed interval. It then releases the bus and waits for the host to take over resume and return the link to active. It sits between the link-state logic (suspend/active/disconnect levels) and the transceiver output mux, in the 48 MHz domain.

## Interface
- IdleUs, 5000: minimum continuous suspend time (µs) before K may be driven; must be < 2^13
- DriveUs, 2000: K-drive duration in µs ticks (spec window 1–15 ms); must be ≥ 1 and < 2^16
- HostWaitUs, 50000: µs allowed after release for the link to become active; must be < 2^16
- clk_48mhz_i  in  1  48 MHz clock; the block's only clock
- rst_ni  in  1  asynchronous active-low reset
- us_tick_i  in  1  one-cycle pulse every 1 µs
- link_suspend_i  in  1  level, link is in a suspended state
- link_active_i  in  1  level, link is active (with or without SOF)
- link_disconnect_i  in  1  level, link disconnected (no VBUS or pull-up off)
- wake_req_i  in  1  pulse, software requests remote wakeup
- usb_oe_o  out  1  output enable to the transceiver while driving K
- usb_dp_o  out  1  D+ drive value (0 while driving K)
- usb_dn_o  out  1  D- drive value (1 while driving K)
- wake_busy_o  out  1  level, a request is in progress (state ≠ Idle)
- wake_done_o  out  1  pulse, wakeup completed (link left suspend)
- wake_fail_o  out  1  pulse, request rejected, aborted or timed out

## Operation
- Suspend timer (13 bits): clears while !link_suspend_i and increments on us_tick_i while link_suspend_i. It saturates at IdleUs; `settled` = (timer == IdleUs).
- Wake timer (16 bits): shared between DriveK and WaitHost. It clears on every state entry and increments on us_tick_i.
- FSM states: Idle, Armed, DriveK, WaitHost.
- Idle transitions:
  - wake_req_i && link_suspend_i && !link_disconnect_i → Armed.
  - wake_req_i otherwise → wake_fail_o pulse, stay Idle.
- Armed transitions, in priority order:
  - link_disconnect_i → Idle, fail.
  - !link_suspend_i (host resumed first) → Idle, done.
  - settled → DriveK.
- DriveK transitions, in priority order:
  - link_disconnect_i → Idle, fail.
  - us_tick_i && timer == DriveUs-1 → WaitHost.
  - In DriveK, link_suspend_i changing is ignored because our own K drive causes it.
- WaitHost transitions, in priority order:
  - link_disconnect_i → Idle, fail.
  - link_active_i → Idle, done.
  - us_tick_i && timer == HostWaitUs-1 → Idle, fail.
- wake_req_i outside Idle is ignored: no queueing, no fail pulse.
- At most one of wake_done_o and wake_fail_o is asserted in any cycle.
- Drive outputs are flops loaded from next-state:
  - usb_oe_o = 1 exactly in cycles where state_q == DriveK.
  - dp/dn = 0/1 while driving; 0/0 otherwise.
  - There is never a cycle with oe=1 and dp=dn.

## Timing
- Reset values: state Idle, both timers 0, usb_oe_o=0, usb_dp_o=0, usb_dn_o=0, wake_busy_o=0, wake_done_o=0, wake_fail_o=0.
- Request accepted at cycle N → Armed at N+1. With settled already true, DriveK and usb_oe_o=1 at N+2.
- K drive lasts exactly DriveUs us_tick_i pulses, counting from DriveK entry. usb_oe_o drops in the cycle after the final tick.
- Done/fail pulses are one cycle wide, registered, and coincide with the first cycle of Idle.
- A disconnect during DriveK releases the bus on the next clock edge.
- Asynchronous reset mid-drive deasserts usb_oe_o immediately, with no pulse.

## Structure
- The state enum `wake_gen_state_e` and the default timing constants (IdleUs, DriveUs, HostWaitUs) live in `usbdev_pkg`, next to the link-state enums.
- No sub-module. The block is a single FSM plus two counters. The top-level usbdev output mux ORs usb_oe_o with the packet transmitter's output enable.

## Test plan
- Suspended 6000 µs, wake_req_i → DriveK two cycles later. oe=1, dp=0, dn=1 for exactly 2000 ticks. Then WaitHost; link_active_i asserted 20000 µs later → one wake_done_o pulse, busy=0.
- Suspended 1000 µs, wake_req_i → Armed holds with oe=0 until suspend reaches 5000 µs, then DriveK.
- wake_req_i with link_suspend_i=0 → wake_fail_o pulse the next cycle, oe never asserted.
- In Armed, link_suspend_i drops before settling → wake_done_o pulse, no K driven.
- Disconnect at tick 500 of DriveK → oe=0 next cycle, wake_fail_o pulse.
- No link_active_i after release → wake_fail_o exactly 50000 ticks after WaitHost entry. A second wake_req_i during busy produces no effect.
